ocd_reply_frame_tx: RTL and testbench

Transmit-side counterpart of the debug coprocessor's UART frame receiver. It takes one reply (type byte plus 32-bit word, e.g. a PRAM read result) on a valid/ready handshake, encodes it as a sync-prefixed, CRC-protected byte frame, and serializes it 8N1 on its own TXD. Its TXD feeds the OCD leg of the top-level UART mux.

---
 rtl/ocd_reply_frame_tx.sv | 170 +++++++++++++++++
 tb/tb_ocd_reply_frame_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ocd_reply_frame_tx.sv
// ocd_reply_frame_tx: sync-prefixed debug reply frame serializer, 8N1 on TXD.
// Define OCD_REPLY_CRC_EN to append a CRC-16/CCITT-FALSE trailer (9-byte frame).
module ocd_reply_frame_tx #(
  parameter int unsigned BAUD_PERIOD = 208,
  parameter logic [7:0]  SYNC0       = 8'h5A,
  parameter logic [7:0]  SYNC1       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [7:0]  frame_type,
  input  logic [31:0] frame_data,
  output logic        TXD,
  output logic        busy,
  output logic        frame_done
);

`ifdef OCD_REPLY_CRC_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd6;
`endif
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_PERIOD - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(BAUD_PERIOD - 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [3:0]  idx_q;
  logic [3:0]  idx_d;
  logic [7:0]  shr_q;
  logic [7:0]  type_q;
  logic [31:0] data_q;
  logic        txd_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        baud_end;
  logic        last_byte;
  logic [7:0]  next_byte;

`ifdef OCD_REPLY_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // MSB-first bitwise CRC over {type, data}, computed once at accept
  function automatic logic [15:0] crc16(input logic [39:0] msg);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 39; i >= 0; i--) begin
      if (c[15] ^ msg[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_d = crc16({frame_type, frame_data});
`endif

  assign baud_end  = (baud_q == BAUD_LAST);
  assign last_byte = (idx_q == LAST_BYTE);
  assign idx_d     = idx_q + 4'd1;

  always_comb begin
    next_byte = SYNC0;
    case (idx_d)
      4'd1:    next_byte = SYNC1;
      4'd2:    next_byte = type_q;
      4'd3:    next_byte = data_q[31:24];
      4'd4:    next_byte = data_q[23:16];
      4'd5:    next_byte = data_q[15:8];
      4'd6:    next_byte = data_q[7:0];
`ifdef OCD_REPLY_CRC_EN
      4'd7:    next_byte = crc_q[15:8];
      4'd8:    next_byte = crc_q[7:0];
`endif
      default: next_byte = SYNC0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
      type_q  <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OCD_REPLY_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE || baud_end) baud_q <= '0;
      else                             baud_q <= baud_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (frame_valid) begin
            type_q  <= frame_type;
            data_q  <= frame_data;
`ifdef OCD_REPLY_CRC_EN
            crc_q   <= crc_d;
`endif
            idx_q   <= '0;
            shr_q   <= SYNC0;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            txd_q   <= shr_q[0];
            shr_q   <= {1'b0, shr_q[7:1]};
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              txd_q <= shr_q[0];
              shr_q <= {1'b0, shr_q[7:1]};
            end
          end
        end
        STOP: begin
          // pulse lands on the final clock of the last stop bit
          done_q <= last_byte && (baud_q == BAUD_PRE);
          if (baud_end) begin
            if (last_byte) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_d;
              shr_q   <= next_byte;
              txd_q   <= 1'b0;
              state_q <= START;
            end
          end
        end
      endcase
    end
  end

  assign TXD         = txd_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_ocd_reply_frame_tx.sv
// tb_ocd_reply_frame_tx: directed bench decoding TXD frames sample by sample.
// Expected bytes and CRC come from a byte-wise CRC model in the bench.
module tb_ocd_reply_frame_tx;

`ifdef OCD_REPLY_CRC_EN
  localparam int NB = 9;
`else
  localparam int NB = 7;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic [7:0]  ftype = '0;
  logic [31:0] fdata = '0;
  logic        ready_a, txd_a, busy_a, done_a;
  logic        ready_b, txd_b, busy_b, done_b;
  logic        sel = 1'b0;
  logic        txd_m, done_m, busy_m, ready_m;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [9];
  logic        smp [$];

  always #5 clk = ~clk;

  ocd_reply_frame_tx #(.BAUD_PERIOD(4)) dut_a (
    .clk(clk), .reset(reset), .frame_valid(valid_a),
    .frame_ready(ready_a), .frame_type(ftype), .frame_data(fdata),
    .TXD(txd_a), .busy(busy_a), .frame_done(done_a)
  );

  ocd_reply_frame_tx #(.BAUD_PERIOD(208)) dut_b (
    .clk(clk), .reset(reset), .frame_valid(valid_b),
    .frame_ready(ready_b), .frame_type(ftype), .frame_data(fdata),
    .TXD(txd_b), .busy(busy_b), .frame_done(done_b)
  );

  assign txd_m   = sel ? txd_b : txd_a;
  assign done_m  = sel ? done_b : done_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign ready_m = sel ? ready_b : ready_a;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                          input logic [7:0] b);
    logic [7:0] x;
    x = c[15:8] ^ b;
    x = x ^ (x >> 4);
    return {c[7:0], 8'h00} ^ ({8'h00, x} << 12) ^ ({8'h00, x} << 5)
           ^ {8'h00, x};
  endfunction

  task automatic set_frame(input logic [7:0] t, input logic [31:0] d);
    logic [15:0] c;
    ftype = t;
    fdata = d;
    exp_q[0] = 8'h5A;
    exp_q[1] = 8'hA5;
    exp_q[2] = t;
    exp_q[3] = d[31:24];
    exp_q[4] = d[23:16];
    exp_q[5] = d[15:8];
    exp_q[6] = d[7:0];
    c = 16'hFFFF;
    for (int i = 2; i < 7; i++) c = crc_upd(c, exp_q[i]);
    exp_q[7] = c[15:8];
    exp_q[8] = c[7:0];
  endtask

  task automatic send(input bit on_b);
    if (on_b) valid_b = 1'b1;
    else      valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Called #1 after the accept edge; returns in the frame_done cycle.
  task automatic capture(input int baud, input string tag);
    int n;
    int glitch;
    logic [9:0] got;
    logic [9:0] want;
    smp.delete();
    n = 0;
    forever begin
      smp.push_back(txd_m);
      if (n == 0) begin
        chk({tag, "_busy"}, 32'(busy_m), 32'd1);
        chk({tag, "_rdy"}, 32'(ready_m), 32'd0);
      end
      if (done_m === 1'b1 || n >= 12 * NB * baud) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n + 1, 10 * NB * baud);
    if (smp.size() >= 10 * NB * baud) begin
      glitch = 0;
      for (int k = 0; k < 10 * NB; k++)
        for (int j = 0; j < baud; j++)
          if (smp[k * baud + j] !== smp[k * baud + baud / 2]) glitch++;
      chk({tag, "_glitch"}, glitch, 0);
      for (int i = 0; i < NB; i++) begin
        for (int b = 0; b < 10; b++)
          got[b] = smp[(10 * i + b) * baud + baud / 2];
        want = {1'b1, exp_q[i], 1'b0};
        chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(want));
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_txd"}, 32'(txd_m), 32'd1);
    chk({tag, "_rdy"}, 32'(ready_m), 32'd1);
    chk({tag, "_busy"}, 32'(busy_m), 32'd0);
    chk({tag, "_done"}, 32'(done_m), 32'd0);
  endtask

  initial begin
    logic [15:0] c;
    int viol;

    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
    chk("crc_model", 32'(c), 32'h29B1);

    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_idle("rst");
    reset = 1'b0;
    viol = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (txd_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 ||
          done_a !== 1'b0 || txd_b !== 1'b1 || ready_b !== 1'b1 ||
          busy_b !== 1'b0 || done_b !== 1'b0) viol++;
    end
    chk("idle_viol", viol, 0);

    set_frame(8'h02, 32'h80007F00);
    send(1'b0);
    capture(4, "f1");
    @(posedge clk);
    #1;
    chk_idle("f1_post");

    set_frame(8'h01, 32'h12345678);
    send(1'b0);
    capture(4, "f2");
    @(posedge clk);
    #1;
    chk_idle("f2_post");

    set_frame(8'h3C, 32'hDEADBEEF);
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    ftype = 8'hC3;
    fdata = 32'h0BADF00D;
    capture(4, "b2b1");
    @(posedge clk);
    #1;
    chk("b2b_gap_txd", 32'(txd_a), 32'd1);
    chk("b2b_gap_rdy", 32'(ready_a), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_acc", 32'(busy_a), 32'd1);
    valid_a = 1'b0;
    set_frame(8'hC3, 32'h0BADF00D);
    capture(4, "b2b2");
    @(posedge clk);
    #1;
    chk_idle("b2b_post");

    set_frame(8'h01, 32'h12345678);
    send(1'b0);
    repeat (31 * 4 + 1) @(posedge clk);
    #1;
    chk("mr_pre_txd", 32'(txd_a), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("mr");
    viol = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_a !== 1'b0) viol++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_a !== 1'b0 || txd_a !== 1'b1) viol++;
    end
    chk("mr_quiet", viol, 0);
    set_frame(8'hA0, 32'h00FF55AA);
    send(1'b0);
    capture(4, "mr_next");
    @(posedge clk);
    #1;

    sel = 1'b1;
    set_frame(8'h02, 32'h80007F00);
    send(1'b1);
    capture(208, "bt");
    @(posedge clk);
    #1;
    chk_idle("bt_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
